// File: rtl/xsw_pkg.sv
// Shared constants and types for the Xwitch crossbar.
// Default geometry, FIFO entry/flag structs, pointer-width helper.
package xsw_pkg;

    localparam int XSW_NUM_PORTS  = 8;
    localparam int XSW_DATA_W     = 8;
    localparam int XSW_ADDR_W     = 8;
    localparam int XSW_FIFO_DEPTH = 8;
    localparam int XSW_AE_LEVEL   = 2;
    localparam int XSW_AF_LEVEL   = 6;

    typedef struct packed {
        logic [XSW_ADDR_W-1:0] addr;
        logic [XSW_DATA_W-1:0] data;
    } xsw_entry_t;

    typedef struct packed {
        logic empty;
        logic full;
        logic ae;
        logic af;
    } xsw_flag_t;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/xsw_param_switch_if.sv
// Port bundle of the Xwitch crossbar: traffic, config and status.
// master drives packets/config, slave is the switch core.
interface xsw_param_switch_if #(
    parameter int NUM_PORTS = 8,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8
);
    logic [NUM_PORTS*ADDR_W-1:0] addr_in;
    logic [NUM_PORTS*DATA_W-1:0] data_in;
    logic [NUM_PORTS-1:0]        wr_en;
    logic [NUM_PORTS-1:0]        data_rcv;
    logic [NUM_PORTS*ADDR_W-1:0] addr_out;
    logic [NUM_PORTS*DATA_W-1:0] data_out;
    logic [NUM_PORTS-1:0]        data_rdy;
    logic [NUM_PORTS-1:0]        rd_en;
    logic                        port_en;
    logic                        port_wr;
    logic [NUM_PORTS-1:0]        port_sel;
    logic [ADDR_W-1:0]           port_addr;
    logic [ADDR_W-1:0]           port_rdata;
    logic [NUM_PORTS-1:0]        err_drop;
    logic [NUM_PORTS-1:0]        fifo_empty;
    logic [NUM_PORTS-1:0]        fifo_full;
    logic [NUM_PORTS-1:0]        fifo_ae;
    logic [NUM_PORTS-1:0]        fifo_af;

    modport master (
        output addr_in, data_in, wr_en, rd_en,
        output port_en, port_wr, port_sel, port_addr,
        input  data_rcv, addr_out, data_out, data_rdy,
        input  port_rdata, err_drop,
        input  fifo_empty, fifo_full, fifo_ae, fifo_af
    );

    modport slave (
        input  addr_in, data_in, wr_en, rd_en,
        input  port_en, port_wr, port_sel, port_addr,
        output data_rcv, addr_out, data_out, data_rdy,
        output port_rdata, err_drop,
        output fifo_empty, fifo_full, fifo_ae, fifo_af
    );
endinterface

// File: rtl/xsw_out_fifo.sv
// Per-output first-word-fall-through FIFO with registered flags.
// A push while full is dropped here as a second line of defence.
module xsw_out_fifo
    import xsw_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AE_LEVEL   = 2,
    parameter int AF_LEVEL   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              valid,
    output xsw_flag_t         flags
);
    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W+DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nx;
    logic          do_push, do_pop;

    assign do_push  = push & ~flags.full;
    assign do_pop   = pop & valid;
    assign count_nx = count + CW'(do_push) - CW'(do_pop);
    assign {rd_addr, rd_data} = valid ? mem[rd_ptr] : '0;

    // storage write, no reset needed on the array
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {wr_addr, wr_data};
    end

    // pointers, occupancy and flags derived from the next count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            flags  <= '{empty: 1'b1, full: 1'b0, ae: 1'b1, af: 1'b0};
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nx;
            valid       <= (count_nx != '0);
            flags.empty <= (count_nx == '0);
            flags.full  <= (count_nx == CW'(FIFO_DEPTH));
            flags.ae    <= (count_nx <= CW'(AE_LEVEL));
            flags.af    <= (count_nx >= CW'(AF_LEVEL));
        end
    end
endmodule

// File: rtl/xsw_param_switch.sv
// Xwitch crossbar: address match, per-output round-robin, output FIFOs.
// Config regs select which address each output answers to.
module xsw_param_switch
    import xsw_pkg::*;
#(
    parameter int NUM_PORTS  = XSW_NUM_PORTS,
    parameter int DATA_W     = XSW_DATA_W,
    parameter int ADDR_W     = XSW_ADDR_W,
    parameter int FIFO_DEPTH = XSW_FIFO_DEPTH,
    parameter int AE_LEVEL   = XSW_AE_LEVEL,
    parameter int AF_LEVEL   = XSW_AF_LEVEL
) (
    input logic clk,
    input logic reset,
    xsw_param_switch_if.slave bus
);
    localparam int N  = NUM_PORTS;
    localparam int SW = ptr_w(N);

    logic [ADDR_W-1:0] areg [N];
    logic [N*N-1:0]    req_all;
    logic [N*N-1:0]    gnt_all;
    logic [N-1:0]      acc;
    logic [N-1:0]      matched;
    logic [ADDR_W-1:0] rd_val;
    logic              rd_found;

    // each valid input requests the lowest output whose address matches
    always_comb begin
        req_all = '0;
        matched = '0;
        for (int i = 0; i < N; i++) begin
            for (int o = 0; o < N; o++) begin
                if (bus.wr_en[i] && !matched[i] &&
                    areg[o] == bus.addr_in[i*ADDR_W +: ADDR_W]) begin
                    req_all[o*N+i] = 1'b1;
                    matched[i]     = 1'b1;
                end
            end
        end
    end

    // accept goes back to whichever input won an output that had room
    always_comb begin
        bus.data_rcv = '0;
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_all[o*N+i] && acc[o]) bus.data_rcv[i] = 1'b1;
            end
        end
    end

    for (genvar o = 0; o < N; o++) begin : g_out
        logic [N-1:0]  req;
        logic [N-1:0]  gnt;
        logic [SW-1:0] win;
        logic [SW-1:0] ptr;
        logic          hit;
        xsw_flag_t     fl;

        assign req                 = req_all[o*N +: N];
        assign gnt_all[o*N +: N]   = gnt;
        assign acc[o]              = hit & ~fl.full & ~reset;

        // round-robin search starting at this output's pointer
        always_comb begin
            gnt = '0;
            win = '0;
            hit = 1'b0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!hit && req[idx]) begin
                    hit      = 1'b1;
                    win      = SW'(idx);
                    gnt[idx] = 1'b1;
                end
            end
        end

        // pointer moves past the winner only when its packet is taken
        always_ff @(posedge clk) begin
            if (reset) ptr <= '0;
            else if (acc[o])
                ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
        end

        xsw_out_fifo #(
            .DATA_W    (DATA_W),
            .ADDR_W    (ADDR_W),
            .FIFO_DEPTH(FIFO_DEPTH),
            .AE_LEVEL  (AE_LEVEL),
            .AF_LEVEL  (AF_LEVEL)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push   (acc[o]),
            .wr_addr(bus.addr_in[int'(win)*ADDR_W +: ADDR_W]),
            .wr_data(bus.data_in[int'(win)*DATA_W +: DATA_W]),
            .pop    (bus.rd_en[o]),
            .rd_addr(bus.addr_out[o*ADDR_W +: ADDR_W]),
            .rd_data(bus.data_out[o*DATA_W +: DATA_W]),
            .valid  (bus.data_rdy[o]),
            .flags  (fl)
        );

        assign bus.fifo_empty[o] = fl.empty;
        assign bus.fifo_full[o]  = fl.full;
        assign bus.fifo_ae[o]    = fl.ae;
        assign bus.fifo_af[o]    = fl.af;
    end

    // readback source: register of the lowest selected output
    always_comb begin
        rd_val   = '0;
        rd_found = 1'b0;
        for (int o = 0; o < N; o++) begin
            if (bus.port_sel[o] && !rd_found) begin
                rd_val   = areg[o];
                rd_found = 1'b1;
            end
        end
    end

    // address registers, readback and drop reporting
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < N; o++) areg[o] <= ADDR_W'(o);
            bus.port_rdata <= '0;
            bus.err_drop   <= '0;
        end else begin
            if (bus.port_en && bus.port_wr) begin
                for (int o = 0; o < N; o++)
                    if (bus.port_sel[o]) areg[o] <= bus.port_addr;
            end
            if (bus.port_en && !bus.port_wr) bus.port_rdata <= rd_val;
            bus.err_drop <= bus.wr_en & ~matched;
        end
    end
endmodule

// File: tb/tb_xsw_param_switch.sv
// Directed bench for xsw_param_switch: vector table plus
// hand-written contention, full, config and reset sequences.
module tb_xsw_param_switch;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    xsw_param_switch_if #(.NUM_PORTS(N), .DATA_W(8), .ADDR_W(8)) bus ();

    xsw_param_switch #(
        .NUM_PORTS(N), .DATA_W(8), .ADDR_W(8),
        .FIFO_DEPTH(8), .AE_LEVEL(2), .AF_LEVEL(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int         src;
        logic [7:0] addr;
        logic [7:0] data;
        int         dst;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.addr_in   = '0;
        bus.data_in   = '0;
        bus.wr_en     = '0;
        bus.rd_en     = '0;
        bus.port_en   = 1'b0;
        bus.port_wr   = 1'b0;
        bus.port_sel  = '0;
        bus.port_addr = '0;
    endtask

    task automatic send(input int src, input logic [7:0] a,
                        input logic [7:0] d);
        bus.wr_en[src]           = 1'b1;
        bus.addr_in[src*8 +: 8]  = a;
        bus.data_in[src*8 +: 8]  = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_in();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg(input logic wr, input logic [7:0] sel,
                       input logic [7:0] a);
        bus.port_en   = 1'b1;
        bus.port_wr   = wr;
        bus.port_sel  = sel;
        bus.port_addr = a;
        tick();
        bus.port_en   = 1'b0;
        bus.port_wr   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_rcv [6];
        logic [7:0] cont_dat [6];

        vecs[0] = '{3, 8'h05, 8'hA5, 5};
        vecs[1] = '{0, 8'h00, 8'h11, 0};
        vecs[2] = '{7, 8'h07, 8'h77, 7};
        vecs[3] = '{1, 8'h06, 8'h3C, 6};
        vecs[4] = '{2, 8'h09, 8'hEE, -1};
        vecs[5] = '{6, 8'h02, 8'h5A, 2};
        vecs[6] = '{5, 8'hFF, 8'h01, -1};
        vecs[7] = '{4, 8'h04, 8'hC3, 4};

        do_reset();

        chk("rst_data_rdy", 32'(bus.data_rdy), 32'h00);
        chk("rst_empty", 32'(bus.fifo_empty), 32'hFF);
        chk("rst_ae", 32'(bus.fifo_ae), 32'hFF);
        chk("rst_full", 32'(bus.fifo_full), 32'h00);
        chk("rst_af", 32'(bus.fifo_af), 32'h00);
        chk("rst_rdata", 32'(bus.port_rdata), 32'h00);
        chk("rst_err", 32'(bus.err_drop), 32'h00);
        chk("rst_dout", 32'(bus.data_out), 32'h0);

        for (int v = 0; v < 8; v++) begin
            clr_in();
            send(vecs[v].src, vecs[v].addr, vecs[v].data);
            #1;
            chk($sformatf("v%0d_rcv", v), 32'(bus.data_rcv),
                vecs[v].dst >= 0 ? 32'(1 << vecs[v].src) : 32'h0);
            tick();
            clr_in();
            chk($sformatf("v%0d_err", v), 32'(bus.err_drop),
                vecs[v].dst < 0 ? 32'(1 << vecs[v].src) : 32'h0);
            if (vecs[v].dst >= 0) begin
                chk($sformatf("v%0d_rdy", v), 32'(bus.data_rdy),
                    32'(1 << vecs[v].dst));
                chk($sformatf("v%0d_dout", v),
                    32'(bus.data_out[vecs[v].dst*8 +: 8]),
                    32'(vecs[v].data));
                chk($sformatf("v%0d_aout", v),
                    32'(bus.addr_out[vecs[v].dst*8 +: 8]),
                    32'(vecs[v].addr));
                bus.rd_en[vecs[v].dst] = 1'b1;
                tick();
                bus.rd_en = '0;
                chk($sformatf("v%0d_pop", v), 32'(bus.data_rdy), 32'h0);
            end
        end

        // contention: inputs 0,2,7 hammer address 4 with reads on
        do_reset();
        exp_rcv  = '{8'h01, 8'h04, 8'h80, 8'h01, 8'h04, 8'h80};
        cont_dat = '{8'h10, 8'h12, 8'h17, 8'h10, 8'h12, 8'h17};
        send(0, 8'h04, 8'h10);
        send(2, 8'h04, 8'h12);
        send(7, 8'h04, 8'h17);
        bus.rd_en[4] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d_rcv", k), 32'(bus.data_rcv),
                32'(exp_rcv[k]));
            if (k > 0)
                chk($sformatf("rr%0d_dout", k), 32'(bus.data_out[4*8 +: 8]),
                    32'(cont_dat[k-1]));
            tick();
        end
        clr_in();
        tick();

        // fill output 1 without reads
        do_reset();
        for (int j = 0; j < 8; j++) begin
            send(0, 8'h01, 8'(j));
            #1;
            chk($sformatf("fill%0d_rcv", j), 32'(bus.data_rcv[0]), 32'h1);
            tick();
            chk($sformatf("fill%0d_af", j), 32'(bus.fifo_af[1]),
                32'(j + 1 >= 6));
            chk($sformatf("fill%0d_full", j), 32'(bus.fifo_full[1]),
                32'(j + 1 == 8));
            chk($sformatf("fill%0d_ae", j), 32'(bus.fifo_ae[1]),
                32'(j + 1 <= 2));
        end
        send(0, 8'h01, 8'h08);
        #1;
        chk("full_9th_rcv", 32'(bus.data_rcv[0]), 32'h0);
        bus.rd_en[1] = 1'b1;
        #1;
        chk("full_pushpop_rcv", 32'(bus.data_rcv[0]), 32'h0);
        tick();
        bus.rd_en = '0;
        chk("full_after_pop", 32'(bus.fifo_full[1]), 32'h0);
        chk("af_after_pop", 32'(bus.fifo_af[1]), 32'h1);
        chk("head_after_pop", 32'(bus.data_out[1*8 +: 8]), 32'h01);
        #1;
        chk("refill_rcv", 32'(bus.data_rcv[0]), 32'h1);
        tick();
        chk("refill_full", 32'(bus.fifo_full[1]), 32'h1);
        clr_in();

        // config write/read, old routing in the write cycle
        do_reset();
        send(1, 8'h02, 8'h99);
        bus.port_en   = 1'b1;
        bus.port_wr   = 1'b1;
        bus.port_sel  = 8'h04;
        bus.port_addr = 8'h20;
        #1;
        chk("cfg_wcyc_rcv", 32'(bus.data_rcv[1]), 32'h1);
        tick();
        clr_in();
        chk("cfg_wcyc_out2", 32'(bus.data_out[2*8 +: 8]), 32'h99);
        bus.rd_en[2] = 1'b1;
        tick();
        bus.rd_en = '0;
        cfg(1'b0, 8'h04, 8'h00);
        chk("cfg_rd_sel4", 32'(bus.port_rdata), 32'h20);
        cfg(1'b0, 8'h08, 8'h00);
        chk("cfg_rd_sel8", 32'(bus.port_rdata), 32'h03);
        cfg(1'b0, 8'h06, 8'h00);
        chk("cfg_rd_lowest", 32'(bus.port_rdata), 32'h01);
        tick();
        chk("cfg_rd_hold", 32'(bus.port_rdata), 32'h01);
        cfg(1'b0, 8'h00, 8'h00);
        chk("cfg_rd_none", 32'(bus.port_rdata), 32'h00);
        cfg(1'b1, 8'h00, 8'h55);
        cfg(1'b0, 8'h01, 8'h00);
        chk("cfg_wr_none", 32'(bus.port_rdata), 32'h00);
        send(3, 8'h20, 8'h42);
        #1;
        chk("cfg_new_rcv", 32'(bus.data_rcv[3]), 32'h1);
        tick();
        clr_in();
        chk("cfg_new_out2", 32'(bus.data_out[2*8 +: 8]), 32'h42);
        chk("cfg_new_rdy", 32'(bus.data_rdy), 32'h04);
        send(1, 8'h02, 8'h13);
        #1;
        chk("cfg_old_rcv", 32'(bus.data_rcv[1]), 32'h0);
        tick();
        clr_in();
        chk("cfg_old_err", 32'(bus.err_drop), 32'h02);
        tick();
        chk("cfg_err_clear", 32'(bus.err_drop), 32'h00);

        // reset in the middle of traffic
        do_reset();
        cfg(1'b1, 8'h40, 8'h66);
        for (int j = 0; j < 5; j++) begin
            send(0, 8'h66, 8'(8'hB0 + j));
            tick();
        end
        chk("mid_ae", 32'(bus.fifo_ae[6]), 32'h0);
        chk("mid_rdy", 32'(bus.data_rdy), 32'h40);
        reset = 1'b1;
        #1;
        chk("mid_rst_rcv", 32'(bus.data_rcv), 32'h0);
        tick();
        reset = 1'b0;
        clr_in();
        chk("mid_empty", 32'(bus.fifo_empty[6]), 32'h1);
        chk("mid_rdy0", 32'(bus.data_rdy), 32'h0);
        cfg(1'b0, 8'h40, 8'h00);
        chk("mid_areg6", 32'(bus.port_rdata), 32'h06);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
